symbol_frame_sync: RTL and testbench

//  Receive-path stage directly upstream of symbol_deserializer. Hunts the raw 2-bit slicer

---
 rtl/symbol_frame_sync_pkg.sv | 20 ++
 rtl/symbol_frame_sync_if.sv | 23 ++
 rtl/symbol_frame_sync_correlator.sv | 27 ++
 rtl/symbol_frame_sync.sv | 136 +++++++++++++
 tb/tb_symbol_frame_sync.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/symbol_frame_sync_pkg.sv
// symbol_frame_sync_pkg: shared constants, FSM state encoding and popcount helper
// for the receive-side frame synchroniser.
package symbol_frame_sync_pkg;
   localparam logic [31:0] SYNC_WORD_DEFAULT = 32'hD391_7A2C;
   localparam int SYMS_PER_BLOCK = 64;
   localparam int HDR_SYMS = 4;
   localparam int SYNC_SYMS = 16;

   typedef enum logic [1:0] {
      ST_HUNT    = 2'd0,
      ST_LEN     = 2'd1,
      ST_PAYLOAD = 2'd2
   } state_e;

   function automatic int popcount32(input logic [31:0] v);
      int n = 0;
      for (int i = 0; i < 32; i++) n += int'(v[i]);
      return n;
   endfunction
endpackage

// File: rtl/symbol_frame_sync_if.sv
// symbol_frame_sync_if: slicer-side symbol stream in, framed payload stream and
// frame status out.
interface symbol_frame_sync_if;
   logic [1:0]  symbol_in;
   logic        symbol_valid;
   logic        resync;
   logic [1:0]  symbol_out;
   logic        symbol_out_valid;
   logic        in_frame;
   logic        frame_start;
   logic        frame_done;
   logic        frame_error;
   logic [15:0] frame_count;

   modport master (
      output symbol_in, symbol_valid, resync,
      input  symbol_out, symbol_out_valid, in_frame, frame_start, frame_done, frame_error, frame_count
   );
   modport slave (
      input  symbol_in, symbol_valid, resync,
      output symbol_out, symbol_out_valid, in_frame, frame_start, frame_done, frame_error, frame_count
   );
endinterface

// File: rtl/symbol_frame_sync_correlator.sv
// sync_correlator: 32-bit symbol shift register with a tolerant sync-word compare;
// match is evaluated on the value the current symbol would shift in.
module sync_correlator
   import symbol_frame_sync_pkg::*;
#(
   parameter logic [31:0] SYNC_WORD = SYNC_WORD_DEFAULT,
   parameter int          SYNC_TOL  = 0
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       shift_i,
   input  logic       clear_i,
   input  logic [1:0] sym_i,
   output logic       match_o
);
   logic [31:0] sr_q, sr_d, sr_new;

   always_comb begin
      sr_new  = {sr_q[29:0], sym_i};
      match_o = popcount32(sr_new ^ SYNC_WORD) <= SYNC_TOL;
      sr_d    = clear_i ? '0 : shift_i ? sr_new : sr_q;
   end

   always_ff @(posedge clk or negedge reset)
      if (!reset) sr_q <= '0;
      else sr_q <= sr_d;
endmodule

// File: rtl/symbol_frame_sync.sv
// symbol_frame_sync: hunts for the sync word, reads an 8-bit block-count header and
// forwards exactly count*SYMS_PER_BLOCK payload symbols; all outputs registered.
module symbol_frame_sync #(
   parameter logic [31:0] SYNC_WORD      = symbol_frame_sync_pkg::SYNC_WORD_DEFAULT,
   parameter int          SYNC_TOL       = 0,
   parameter int          SYMS_PER_BLOCK = symbol_frame_sync_pkg::SYMS_PER_BLOCK
) (
   input  logic clk,
   input  logic reset,
   symbol_frame_sync_if.slave sif
);
   import symbol_frame_sync_pkg::*;

   localparam int CNT_W = $clog2(SYMS_PER_BLOCK);

   state_e            state_q, state_d;
   logic [1:0]        hdr_cnt_q, hdr_cnt_d;
   logic [7:0]        len_q, len_d, blocks_q, blocks_d;
   logic [CNT_W-1:0]  sym_cnt_q, sym_cnt_d;
   logic [1:0]        sym_out_q, sym_out_d;
   logic              out_valid_q, out_valid_d, in_frame_q, in_frame_d;
   logic              start_q, start_d, done_q, done_d, err_q, err_d;
   logic [15:0]       count_q, count_d;
   logic              shift, clear, match, last_sym;

   sync_correlator #(.SYNC_WORD(SYNC_WORD), .SYNC_TOL(SYNC_TOL)) u_corr (
      .clk     (clk),
      .reset   (reset),
      .shift_i (shift),
      .clear_i (clear),
      .sym_i   (sif.symbol_in),
      .match_o (match)
   );

   assign last_sym = sym_cnt_q == CNT_W'(SYMS_PER_BLOCK - 1);

   // Every path back to HUNT also clears the correlator so stale bits never seed a match.
   always_comb begin
      state_d     = state_q;
      hdr_cnt_d   = hdr_cnt_q;
      len_d       = len_q;
      blocks_d    = blocks_q;
      sym_cnt_d   = sym_cnt_q;
      sym_out_d   = sym_out_q;
      out_valid_d = 1'b0;
      start_d     = 1'b0;
      done_d      = 1'b0;
      err_d       = 1'b0;
      count_d     = count_q;
      shift       = 1'b0;
      clear       = 1'b0;
      if (sif.resync) begin
         state_d = ST_HUNT;
         clear   = 1'b1;
         err_d   = state_q != ST_HUNT;
      end else if (sif.symbol_valid) begin
         case (state_q)
            ST_HUNT: begin
               shift = 1'b1;
               if (match) begin
                  state_d   = ST_LEN;
                  start_d   = 1'b1;
                  hdr_cnt_d = '0;
               end
            end
            ST_LEN: begin
               len_d     = {len_q[5:0], sif.symbol_in};
               hdr_cnt_d = hdr_cnt_q + 2'd1;
               if (hdr_cnt_q == 2'(HDR_SYMS - 1)) begin
                  state_d   = len_d == 8'd0 ? ST_HUNT : ST_PAYLOAD;
                  err_d     = len_d == 8'd0;
                  clear     = len_d == 8'd0;
                  blocks_d  = len_d;
                  sym_cnt_d = '0;
               end
            end
            ST_PAYLOAD: begin
               out_valid_d = 1'b1;
               sym_out_d   = sif.symbol_in;
               sym_cnt_d   = last_sym ? '0 : sym_cnt_q + 1'b1;
               if (last_sym) begin
                  blocks_d = blocks_q - 8'd1;
                  if (blocks_q == 8'd1) begin
                     done_d  = 1'b1;
                     count_d = count_q + 16'd1;
                     state_d = ST_HUNT;
                     clear   = 1'b1;
                  end
               end
            end
            default: begin
               state_d = ST_HUNT;
               clear   = 1'b1;
            end
         endcase
      end
      in_frame_d = state_d != ST_HUNT;
   end

   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         state_q     <= ST_HUNT;
         hdr_cnt_q   <= '0;
         len_q       <= '0;
         blocks_q    <= '0;
         sym_cnt_q   <= '0;
         sym_out_q   <= '0;
         out_valid_q <= 1'b0;
         in_frame_q  <= 1'b0;
         start_q     <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         count_q     <= '0;
      end else begin
         state_q     <= state_d;
         hdr_cnt_q   <= hdr_cnt_d;
         len_q       <= len_d;
         blocks_q    <= blocks_d;
         sym_cnt_q   <= sym_cnt_d;
         sym_out_q   <= sym_out_d;
         out_valid_q <= out_valid_d;
         in_frame_q  <= in_frame_d;
         start_q     <= start_d;
         done_q      <= done_d;
         err_q       <= err_d;
         count_q     <= count_d;
      end

   assign sif.symbol_out       = sym_out_q;
   assign sif.symbol_out_valid = out_valid_q;
   assign sif.in_frame         = in_frame_q;
   assign sif.frame_start      = start_q;
   assign sif.frame_done       = done_q;
   assign sif.frame_error      = err_q;
   assign sif.frame_count      = count_q;
endmodule

// File: tb/tb_symbol_frame_sync.sv
// tb_symbol_frame_sync: scoreboard bench; driven payload symbols are queued with their
// drive cycle and popped as the DUT forwards them.
module tb_symbol_frame_sync;
   import symbol_frame_sync_pkg::*;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   symbol_frame_sync_if sif0 ();
   symbol_frame_sync_if sif1 ();
   assign sif1.symbol_in    = sif0.symbol_in;
   assign sif1.symbol_valid = sif0.symbol_valid;
   assign sif1.resync       = sif0.resync;

   symbol_frame_sync #(.SYNC_TOL(0)) dut (.clk(clk), .reset(reset), .sif(sif0.slave));
   symbol_frame_sync #(.SYNC_TOL(1)) dut_t1 (.clk(clk), .reset(reset), .sif(sif1.slave));

   typedef struct {
      logic [1:0] sym;
      int         cyc;
   } exp_t;
   exp_t q[$];
   exp_t e;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int passed = 0, total = 0;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   int n_start = 0, n_start1 = 0, n_done = 0, n_err = 0, n_valid = 0;
   int done_cyc = 0, err_cyc = 0;
   always @(negedge clk) begin
      if (sif0.symbol_out_valid) begin
         n_valid++;
         if (q.size() == 0) check("unexpected_valid", 1, 0);
         else begin
            e = q.pop_front();
            check("sym", 32'(sif0.symbol_out), 32'(e.sym));
            check("latency", cyc, e.cyc + 1);
         end
      end
      if (sif0.frame_start) begin
         n_start++;
         check("in_frame_at_start", 32'(sif0.in_frame), 1);
      end
      if (sif0.frame_done) begin
         n_done++;
         done_cyc = cyc;
         check("in_frame_at_done", 32'(sif0.in_frame), 0);
         check("done_err_excl", 32'(sif0.frame_error), 0);
         check("done_q_empty", q.size(), 0);
      end
      if (sif0.frame_error) begin
         n_err++;
         err_cyc = cyc;
         check("in_frame_at_err", 32'(sif0.in_frame), 0);
      end
      if (sif1.frame_start) n_start1++;
   end

   int last_cyc = 0;
   bit duty = 0;
   int exp_frames = 0;

   task automatic drive(input logic [1:0] s, input logic v, input logic r);
      @(posedge clk);
      #1;
      sif0.symbol_in    = s;
      sif0.symbol_valid = v;
      sif0.resync       = r;
   endtask

   task automatic send(input logic [1:0] s, input bit push);
      if (duty) while ($urandom_range(0, 1) == 1) drive(2'($urandom), 1'b0, 1'b0);
      drive(s, 1'b1, 1'b0);
      last_cyc = cyc;
      if (push) q.push_back('{sym: s, cyc: cyc});
   endtask

   task automatic send_word(input logic [31:0] w);
      for (int i = 15; i >= 0; i--) send(w[2*i+:2], 1'b0);
   endtask

   task automatic send_hdr(input logic [7:0] l);
      for (int i = 3; i >= 0; i--) send(l[2*i+:2], 1'b0);
   endtask

   task automatic send_payload(input int n, input bit push, input bit rnd);
      for (int i = 0; i < n; i++) send(rnd ? 2'($urandom) : 2'(i % 4), push);
   endtask

   task automatic idle(input int n);
      repeat (n) drive(2'd0, 1'b0, 1'b0);
   endtask

   task automatic wait_drain();
      int t = 0;
      while (q.size() != 0 && t < 1000) begin
         @(negedge clk);
         t++;
      end
      check("drain", q.size(), 0);
   endtask

   task automatic reset_mid_frame();
      int nv;
      send_word(SYNC_WORD_DEFAULT);
      send_hdr(8'd1);
      send_payload(20, 1'b1, 1'b0);
      idle(1);
      @(posedge clk);
      #1 reset = 1'b0;
      #1;
      check("rst_valid", 32'(sif0.symbol_out_valid), 0);
      check("rst_sym", 32'(sif0.symbol_out), 0);
      check("rst_in_frame", 32'(sif0.in_frame), 0);
      check("rst_pulses", {29'd0, sif0.frame_start, sif0.frame_done, sif0.frame_error}, 0);
      check("rst_count", 32'(sif0.frame_count), 0);
      exp_frames = 0;
      @(posedge clk);
      #1 reset = 1'b1;
      nv = n_valid;
      send_payload(64, 1'b0, 1'b0);
      idle(2);
      check("rst_no_fwd", n_valid, nv);
   endtask

   task automatic good_frame(input logic [7:0] len, input bit rnd);
      int nd, nv;
      nd = n_done;
      nv = n_valid;
      send_word(SYNC_WORD_DEFAULT);
      send_hdr(len);
      send_payload(int'(len) * SYMS_PER_BLOCK, 1'b1, rnd);
      idle(2);
      exp_frames++;
      check("frame_done", n_done, nd + 1);
      check("done_cyc", done_cyc, last_cyc + 1);
      check("fwd_count", n_valid, nv + int'(len) * SYMS_PER_BLOCK);
      check("frame_count", 32'(sif0.frame_count), exp_frames);
   endtask

   initial begin
      int ne, nd, nv, s0, s1, hc, rc;
      sif0.symbol_in    = 2'd0;
      sif0.symbol_valid = 1'b0;
      sif0.resync       = 1'b0;
      #2 reset = 1'b0;
      #1;
      check("init_outputs", {sif0.symbol_out, sif0.symbol_out_valid, sif0.in_frame, sif0.frame_start,
                             sif0.frame_done, sif0.frame_error, sif0.frame_count}, 0);
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;

      reset_mid_frame();
      good_frame(8'd1, 1'b0);

      ne = n_err;
      nv = n_valid;
      send_word(SYNC_WORD_DEFAULT);
      send_hdr(8'd0);
      hc = last_cyc;
      idle(2);
      check("zero_len_err", n_err, ne + 1);
      check("zero_len_err_cyc", err_cyc, hc + 1);
      check("zero_len_no_fwd", n_valid, nv);
      good_frame(8'd1, 1'b1);

      ne = n_err;
      drive(2'd0, 1'b0, 1'b1);
      idle(1);
      s0 = n_start;
      s1 = n_start1;
      send_word(32'hD391_7A2D);
      idle(2);
      check("tol0_no_start", n_start, s0);
      check("tol1_start", n_start1, s1 + 1);
      drive(2'd0, 1'b0, 1'b1);
      idle(1);
      check("hunt_resync_no_err", n_err, ne);

      duty = 1;
      good_frame(8'd2, 1'b1);
      good_frame(8'd2, 1'b1);
      duty = 0;

      ne = n_err;
      nd = n_done;
      nv = n_valid;
      send_word(SYNC_WORD_DEFAULT);
      send_hdr(8'd1);
      send_payload(29, 1'b1, 1'b1);
      drive(2'd3, 1'b1, 1'b1);
      rc = cyc;
      send_payload(34, 1'b0, 1'b0);
      idle(2);
      check("abort_err", n_err, ne + 1);
      check("abort_err_cyc", err_cyc, rc + 1);
      check("abort_no_done", n_done, nd);
      check("abort_fwd", n_valid, nv + 29);
      check("abort_count", 32'(sif0.frame_count), exp_frames);
      good_frame(8'd1, 1'b0);

      reset_mid_frame();
      wait_drain();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit (%0d/%0d)", passed, total);
      $fatal(1);
   end
endmodule
